// File: rtl/aes_spi_pkg.sv
// -----------------------------------------------------------------------------
// aes_spi_pkg
// Shared types and constants for the AES SPI front end.
//   state_t         : one-hot FSM state encoding (IDLE, LOAD, START, BUSY, DONE)
//   BLK_W_DEF       : default AES block/key width
//   FRAME_W         : SPI frame width (plaintext followed by key)
//   CNT_W           : width of the received-bit counter (counts 0..FRAME_W)
//   SYNC_STAGES_DEF : default depth of each input synchronizer
// -----------------------------------------------------------------------------
package aes_spi_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int BLK_W_DEF       = 128;
  localparam int FRAME_W         = 2 * BLK_W_DEF;
  localparam int CNT_W           = $clog2(FRAME_W + 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    START = 5'b00100,
    BUSY  = 5'b01000,
    DONE  = 5'b10000
  } state_t;

endpackage

// File: rtl/sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Flop-chain synchronizer that brings one asynchronous bit into the clk domain.
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous, active-high reset (chain clears to 0)
//   i_d     : asynchronous input
//   o_q     : synchronized output, STAGES clk cycles behind i_d
// -----------------------------------------------------------------------------
module sync_bit
  import aes_spi_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous bit through the synchronizer chain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_chain <= {STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/aes_spi_frontend.sv
// -----------------------------------------------------------------------------
// aes_spi_frontend
// SPI slave front end for the AES core. Receives a 2*BLK_W-bit frame
// {plaintext, key} MSB first, pulses start to the core, captures the
// cyphertext when the core finishes and shifts it back out on o_sdo.
// SPI pins are asynchronous and oversampled in the single clk domain.
//
// Ports:
//   i_clk         : system clock
//   i_reset       : synchronous, active-high reset
//   i_sck         : SPI clock from MCU (async)
//   i_sdi         : SPI data in (async), sampled on sck rising edge
//   o_sdo         : SPI data out, advances after sck falling edges
//   i_load        : frame strobe from MCU (async), high while loading
//   o_done        : result ready, high until the next load
//   o_key         : key to the core
//   o_plaintext   : plaintext to the core
//   o_start       : one-clk start pulse to the core
//   i_core_done   : core result valid (level or pulse)
//   i_cyphertext  : core result, valid while i_core_done is high
//
// Configuration macro:
//   AES_SPI_LEN_CHECK_EN : when defined, a frame whose bit count is not
//                          exactly 2*BLK_W is dropped (back to IDLE, no start).
// -----------------------------------------------------------------------------
module aes_spi_frontend
  import aes_spi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int BLK_W       = BLK_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sck,
  input  logic             i_sdi,
  output logic             o_sdo,
  input  logic             i_load,
  output logic             o_done,
  output logic [BLK_W-1:0] o_key,
  output logic [BLK_W-1:0] o_plaintext,
  output logic             o_start,
  input  logic             i_core_done,
  input  logic [BLK_W-1:0] i_cyphertext
);

  localparam int FRM_W  = 2 * BLK_W;
  localparam int CNT_WL = $clog2(FRM_W + 1);
  localparam logic [CNT_WL-1:0] CNT_FULL = CNT_WL'(FRM_W);
  localparam logic [CNT_WL-1:0] CNT_ONE  = CNT_WL'(1);

  // Synchronized pins and their edge strobes
  logic w_sck_s;
  logic w_sdi_s;
  logic w_load_s;
  logic r_sck_d;
  logic r_load_d;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_load_rise;
  logic w_load_fall;

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // Datapath
  logic [CNT_WL-1:0] r_bitcnt;
  logic [CNT_WL-1:0] w_bitcnt_nxt;
  logic [FRM_W-1:0]  r_shreg;
  logic [FRM_W-1:0]  w_shreg_nxt;
  logic [BLK_W-1:0]  r_outreg;
  logic [BLK_W-1:0]  r_key;
  logic [BLK_W-1:0]  r_plaintext;
  logic              r_start;
  logic              r_done;
  logic              w_len_ok;

  // Decoded actions from the FSM output process
  logic w_start_nxt;
  logic w_done_nxt;
  logic w_latch;
  logic w_capture;
  logic w_enter_load;
  logic w_shift_out;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_sck),
    .o_q     (w_sck_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_sdi),
    .o_q     (w_sdi_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_load (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_load),
    .o_q     (w_load_s)
  );

  assign w_sck_rise  =  w_sck_s  & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s  &  r_sck_d;
  assign w_load_rise =  w_load_s & ~r_load_d;
  assign w_load_fall = ~w_load_s &  r_load_d;

  // Receive shifter: the bit arriving on this cycle's sck rise is folded in
  // before any latch decision, so a coincident load fall still sees it.
  always_comb begin
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    if ((r_state == LOAD) && w_sck_rise) begin
      w_shreg_nxt = {r_shreg[FRM_W-2:0], w_sdi_s};
      if (r_bitcnt != CNT_FULL) begin
        w_bitcnt_nxt = r_bitcnt + CNT_ONE;
      end else begin
        w_bitcnt_nxt = r_bitcnt;
      end
    end else begin
      w_shreg_nxt  = r_shreg;
      w_bitcnt_nxt = r_bitcnt;
    end
  end

`ifdef AES_SPI_LEN_CHECK_EN
  assign w_len_ok = (w_bitcnt_nxt == CNT_FULL);
`else
  assign w_len_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a load rise in BUSY beats a simultaneous core_done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_load_s ? LOAD : IDLE;
      end
      LOAD: begin
        if (w_load_fall) begin
          w_state_nxt = w_len_ok ? START : IDLE;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      START: begin
        w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_load_rise) begin
          w_state_nxt = LOAD;
        end else if (i_core_done) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        w_state_nxt = w_load_rise ? LOAD : DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM output decode; everything here feeds registers so outputs stay glitch-free.
  always_comb begin
    w_start_nxt  = (w_state_nxt == START);
    w_done_nxt   = (w_state_nxt == DONE);
    w_latch      = (r_state == LOAD) && (w_state_nxt == START);
    w_capture    = (r_state == BUSY) && (w_state_nxt == DONE);
    w_enter_load = (w_state_nxt == LOAD) && (r_state != LOAD);
    w_shift_out  = (r_state == DONE) && (w_state_nxt == DONE) && w_sck_fall;
  end

  // Datapath registers: edge history, counters, shifters and core handoff.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_d     <= 1'b0;
      r_load_d    <= 1'b0;
      r_bitcnt    <= {CNT_WL{1'b0}};
      r_shreg     <= {FRM_W{1'b0}};
      r_outreg    <= {BLK_W{1'b0}};
      r_key       <= {BLK_W{1'b0}};
      r_plaintext <= {BLK_W{1'b0}};
      r_start     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sck_d  <= w_sck_s;
      r_load_d <= w_load_s;
      r_start  <= w_start_nxt;
      r_done   <= w_done_nxt;
      r_shreg  <= w_shreg_nxt;

      if (w_enter_load) begin
        r_bitcnt <= {CNT_WL{1'b0}};
      end else begin
        r_bitcnt <= w_bitcnt_nxt;
      end

      if (w_latch) begin
        r_plaintext <= w_shreg_nxt[FRM_W-1:BLK_W];
        r_key       <= w_shreg_nxt[BLK_W-1:0];
      end

      // Clearing outreg on a new load keeps sdo low outside the readout phase.
      if (w_enter_load) begin
        r_outreg <= {BLK_W{1'b0}};
      end else if (w_capture) begin
        r_outreg <= i_cyphertext;
      end else if (w_shift_out) begin
        r_outreg <= {r_outreg[BLK_W-2:0], 1'b0};
      end
    end
  end

  assign o_sdo       = r_outreg[BLK_W-1];
  assign o_done      = r_done;
  assign o_start     = r_start;
  assign o_key       = r_key;
  assign o_plaintext = r_plaintext;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// -----------------------------------------------------------------------------
// tb_aes_spi_frontend
// Scoreboard bench for aes_spi_frontend. Stimulus pushes expected core handoff
// values and expected readouts into queues; independent monitors pop and
// compare whenever start pulses or a full 128-bit readout completes.
// -----------------------------------------------------------------------------
module tb_aes_spi_frontend;
  import aes_spi_pkg::*;

  localparam int BW   = 128;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          sck;
  logic          sdi;
  logic          load;
  logic          core_done;
  logic [BW-1:0] ct_in;
  logic          o_sdo;
  logic          o_done;
  logic          o_start;
  logic [BW-1:0] o_key;
  logic [BW-1:0] o_plaintext;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FRAME_W-1:0] exp_start_q[$];
  logic [BW-1:0]      exp_rd_q[$];
  bit                 sent_q[$];

  logic          prev_start = 1'b0;
  logic [BW-1:0] rd_bits    = '0;
  int            rd_n       = 0;

  always #5 clk = ~clk;

  aes_spi_frontend dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_sck        (sck),
    .i_sdi        (sdi),
    .o_sdo        (o_sdo),
    .i_load       (load),
    .o_done       (o_done),
    .o_key        (o_key),
    .o_plaintext  (o_plaintext),
    .o_start      (o_start),
    .i_core_done  (core_done),
    .i_cyphertext (ct_in)
  );

  task automatic chk(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: the core sees the last FRAME_W bits sent, first sent = MSB.
  function automatic logic [FRAME_W-1:0] model_frame();
    logic [FRAME_W-1:0] f;
    int sz;
    f  = '0;
    sz = sent_q.size();
    for (int i = 0; i < FRAME_W; i++) begin
      if (sz - 1 - i >= 0) f[i] = sent_q[sz - 1 - i];
    end
    return f;
  endfunction

  // Monitor: every start pulse must be single-cycle and carry the expected frame.
  always @(negedge clk) begin
    if (o_start === 1'b1) begin
      chk("start_single", prev_start, 1'b0);
      chk("start_expected", (exp_start_q.size() != 0), 1'b1);
      if (exp_start_q.size() != 0) begin
        logic [FRAME_W-1:0] e;
        e = exp_start_q.pop_front();
        chk("plaintext", o_plaintext, e[FRAME_W-1:BW]);
        chk("key", o_key, e[BW-1:0]);
      end
    end
    prev_start = o_start;
  end

  // Monitor: collect sdo at each MCU sck rise while done is high.
  always @(posedge sck) begin
    if (o_done === 1'b1) begin
      rd_bits = {rd_bits[BW-2:0], o_sdo};
      rd_n++;
      if (rd_n == BW) begin
        chk("rd_expected", (exp_rd_q.size() != 0), 1'b1);
        if (exp_rd_q.size() != 0) chk("readout", rd_bits, exp_rd_q.pop_front());
        rd_n = 0;
      end
    end else begin
      rd_n = 0;
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic shift_bits(input logic [FRAME_W+7:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = data[i];
      sent_q.push_back(data[i]);
      clk_wait(HALF);
      sck = 1'b1;
      clk_wait(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [FRAME_W+7:0] data, input int n);
    sent_q.delete();
    load = 1'b1;
    clk_wait(8);
    shift_bits(data, n);
    clk_wait(HALF);
    load = 1'b0;
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("start_seen", seen, 1'b1);
  endtask

  task automatic core_respond(input logic [BW-1:0] ct);
    clk_wait(3);
    ct_in     = ct;
    core_done = 1'b1;
    @(negedge clk);
    chk("done_before", o_done, 1'b0);
    @(negedge clk);
    chk("done_latency", o_done, 1'b1);
  endtask

  task automatic core_hold(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #2;
      ct_in = rand128();
    end
    core_done = 1'b0;
    ct_in     = rand128();
  endtask

  task automatic readout();
    for (int i = 0; i < BW; i++) begin
      clk_wait(HALF);
      sck = 1'b1;
      clk_wait(HALF);
      sck = 1'b0;
    end
    clk_wait(HALF);
    chk("sdo_zero_after", o_sdo, 1'b0);
    chk("done_held", o_done, 1'b1);
  endtask

  // Full transaction: frame in, core handoff, result out.
  task automatic run_frame(input logic [FRAME_W+7:0] data, input int n,
                           input logic [BW-1:0] ct, input int hold);
    send_bits(data, n);
    exp_start_q.push_back(model_frame());
    exp_rd_q.push_back(ct);
    wait_start();
    core_respond(ct);
    fork
      core_hold(hold);
      readout();
    join
  endtask

  // Watchdog: a hung handshake still produces a summary.
  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [FRAME_W-1:0] f;
    logic [BW-1:0]      ct;
    logic [BW-1:0]      k_prev;
    logic [BW-1:0]      p_prev;

    reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
    core_done = 1'b0; ct_in = '0;
    clk_wait(4);
    @(negedge clk);
    chk("rst_sdo", o_sdo, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_start", o_start, 1'b0);
    chk("rst_key", o_key, '0);
    chk("rst_pt", o_plaintext, '0);
    reset = 1'b0;
    clk_wait(4);

    // 1: FIPS-197 A.1 / B
    f = {128'h3243F6A8_885A308D_313198A2_E0370734, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C};
    run_frame({8'h00, f}, FRAME_W, 128'h3925841D_02DC09FB_DC118597_196A0B32, 1);

    // 2: Appendix C.1
    f = {128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h00010203_04050607_08090A0B_0C0D0E0F};
    run_frame({8'h00, f}, FRAME_W, 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A, 1);

    // 3: oversize frame keeps the last FRAME_W bits
    f = {rand128(), rand128()};
    run_frame({4'h0, 4'($urandom), f}, FRAME_W + 4, rand128(), 1);
    k_prev = f[BW-1:0];
    p_prev = f[FRAME_W-1:BW];
`ifdef AES_SPI_LEN_CHECK_EN
    send_bits({8'h00, rand128(), rand128()}, FRAME_W - 1);
    clk_wait(20);
    chk("short_done", o_done, 1'b0);
    chk("short_key", o_key, k_prev);
    chk("short_pt", o_plaintext, p_prev);
`endif

    // 4: load rises in BUSY on the same cycle core_done is seen -> abort
    f = {rand128(), rand128()};
    send_bits({8'h00, f}, FRAME_W);
    exp_start_q.push_back(model_frame());
    wait_start();
    load = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    ct_in     = {1'b1, rand128() >> 1} | {1'b1, {(BW-1){1'b0}}};
    core_done = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_done", o_done, 1'b0);
    chk("abort_sdo", o_sdo, 1'b0);
    core_done = 1'b0;
    f = {rand128(), rand128()};
    run_frame({8'h00, f}, FRAME_W, rand128(), 1);

    // 5: reset after 100 bits, then a fresh frame
    sent_q.delete();
    load = 1'b1;
    clk_wait(8);
    shift_bits({rand128(), rand128(), 8'h00}, 100);
    reset = 1'b1;
    load  = 1'b0;
    clk_wait(1);
    @(negedge clk);
    chk("mid_rst_sdo", o_sdo, 1'b0);
    chk("mid_rst_done", o_done, 1'b0);
    chk("mid_rst_start", o_start, 1'b0);
    chk("mid_rst_key", o_key, '0);
    chk("mid_rst_pt", o_plaintext, '0);
    clk_wait(3);
    reset = 1'b0;
    clk_wait(4);
    f = {rand128(), rand128()};
    run_frame({8'h00, f}, FRAME_W, rand128(), 1);

    // 6: core_done held high while reading out
    f  = {rand128(), rand128()};
    ct = rand128();
    run_frame({8'h00, f}, FRAME_W, ct, 50);

    clk_wait(10);
    chk("start_q_empty", exp_start_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
